// File: rtl/serial_master_port_if.sv
// ============================================================================
// Module   : serial_master_port_if
// Purpose  : Shared serial-bus signal bundle between the master port, the
//            arbiter and one serial memory slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_master_port_if;
  logic bus_req;
  logic bus_grant;
  logic m_valid;
  logic m_wren;
  logic m_addr;
  logic m_data;
  logic m_burst_en;
  logic s_ready;
  logic s_valid;
  logic s_data;

  modport master (
    output bus_req,
    output m_valid,
    output m_wren,
    output m_addr,
    output m_data,
    output m_burst_en,
    input  bus_grant,
    input  s_ready,
    input  s_valid,
    input  s_data
  );

  modport slave (
    input  bus_req,
    input  m_valid,
    input  m_wren,
    input  m_addr,
    input  m_data,
    input  m_burst_en,
    output bus_grant,
    output s_ready,
    output s_valid,
    output s_data
  );
endinterface

`default_nettype wire

// File: rtl/serial_master_port.sv
// ============================================================================
// Module   : serial_master_port
// Purpose  : Single-transfer serial bus master. Arbitrates for the bus,
//            shifts address/write data out MSB-first and deserializes the
//            read byte. Optional wait timeout: SERIAL_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_master_port #(
  parameter int N   = 8,
  parameter int ADN = 12
`ifdef SERIAL_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req,
  input  logic           wr,
  input  logic [ADN-1:0] addr,
  input  logic [N-1:0]   wdata,
  output logic [N-1:0]   rdata,
  output logic           done,
  output logic           busy,
`ifdef SERIAL_MASTER_TIMEOUT_EN
  output logic           err,
`endif
  serial_master_port_if.master bus
);

  localparam int c_CNT_W = $clog2(ADN) + 1;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_REQ     = 3'd1;
  localparam logic [2:0] c_START   = 3'd2;
  localparam logic [2:0] c_ADDR    = 3'd3;
  localparam logic [2:0] c_WR_ACK  = 3'd4;
  localparam logic [2:0] c_RD_WAIT = 3'd5;
  localparam logic [2:0] c_RD_DATA = 3'd6;
  localparam logic [2:0] c_DONE    = 3'd7;

  localparam logic [c_CNT_W-1:0] c_ADDR_LAST  = c_CNT_W'(ADN - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_FIRST = c_CNT_W'(ADN - N);
  localparam logic [c_CNT_W-1:0] c_BYTE_LAST  = c_CNT_W'(N - 1);

  generate
    if (ADN < N) begin : g_paramCheck
      $error("serial_master_port: ADN must be >= N");
    end
  endgenerate

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_bitCnt;
  logic               r_wr;
  logic [ADN-1:0]     r_addrSh;
  logic [N-1:0]       r_wdSh;
  logic [N-1:0]       r_rdSh;
  logic [N-1:0]       r_rdata;

  logic               w_grantOk;
  logic               w_ackOk;
  logic               w_waitState;
  logic               w_toFire;
  logic [N-1:0]       w_rdNext;

  assign w_grantOk   = bus.bus_grant && bus.s_ready;
  // Write commit needs at least two WR_ACK cycles before s_ready is honoured.
  assign w_ackOk     = (r_bitCnt != '0) && bus.s_ready;
  assign w_waitState = (r_state == c_REQ) || (r_state == c_WR_ACK) ||
                       (r_state == c_RD_WAIT);
  assign w_rdNext    = {r_rdSh[N-2:0], bus.s_data};

`ifdef SERIAL_MASTER_TIMEOUT_EN
  localparam int c_TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

  logic [c_TO_W-1:0] r_toCnt;
  logic              r_err;
  logic              w_exitWait;

  assign w_exitWait = ((r_state == c_REQ)     && w_grantOk) ||
                      ((r_state == c_WR_ACK)  && w_ackOk)   ||
                      ((r_state == c_RD_WAIT) && bus.s_valid);
  assign w_toFire   = w_waitState && !w_exitWait && (r_toCnt == c_TO_LAST);
  assign err        = r_err;

  // Counter is zero on entry to every wait state because any exit clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_toCnt <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_toFire;
      if (w_waitState && !w_exitWait && !w_toFire)
        r_toCnt <= r_toCnt + 1'b1;
      else
        r_toCnt <= '0;
    end
  end
`else
  assign w_toFire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_bitCnt <= '0;
      r_wr     <= 1'b0;
      r_addrSh <= '0;
      r_wdSh   <= '0;
      r_rdSh   <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req) begin
            r_wr     <= wr;
            r_addrSh <= addr;
            r_wdSh   <= wdata;
            r_bitCnt <= '0;
            r_state  <= c_REQ;
          end
        end

        c_REQ: begin
          if (w_grantOk)
            r_state <= c_START;
          else if (w_toFire)
            r_state <= c_DONE;
        end

        c_START: begin
          r_bitCnt <= '0;
          r_state  <= c_ADDR;
        end

        c_ADDR: begin
          r_addrSh <= {r_addrSh[ADN-2:0], 1'b0};
          if (r_bitCnt >= c_DATA_FIRST)
            r_wdSh <= {r_wdSh[N-2:0], 1'b0};
          if (r_bitCnt == c_ADDR_LAST) begin
            r_bitCnt <= '0;
            r_state  <= r_wr ? c_WR_ACK : c_RD_WAIT;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end

        c_WR_ACK: begin
          if (w_ackOk || w_toFire) begin
            r_bitCnt <= '0;
            r_state  <= c_DONE;
          end else if (r_bitCnt == '0) begin
            r_bitCnt <= c_CNT_W'(1);
          end
        end

        // The first s_valid beat is the slave's load cycle; its data is dropped.
        c_RD_WAIT: begin
          if (bus.s_valid) begin
            r_bitCnt <= '0;
            r_state  <= c_RD_DATA;
          end else if (w_toFire) begin
            r_state <= c_DONE;
          end
        end

        c_RD_DATA: begin
          if (bus.s_valid) begin
            r_rdSh <= w_rdNext;
            if (r_bitCnt == c_BYTE_LAST) begin
              r_rdata  <= w_rdNext;
              r_bitCnt <= '0;
              r_state  <= c_DONE;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy  = (r_state != c_IDLE);
  assign done  = (r_state == c_DONE);
  assign rdata = r_rdata;

  assign bus.bus_req    = busy && !done;
  assign bus.m_valid    = (r_state == c_START) || (r_state == c_ADDR);
  assign bus.m_wren     = r_wr && ((r_state == c_START)   || (r_state == c_ADDR)    ||
                                   (r_state == c_WR_ACK)  || (r_state == c_RD_WAIT) ||
                                   (r_state == c_RD_DATA));
  assign bus.m_addr     = (r_state == c_ADDR) && r_addrSh[ADN-1];
  // Write data rides on the last N address cycles so both fields end together.
  assign bus.m_data     = (r_state == c_ADDR) && r_wr &&
                          (r_bitCnt >= c_DATA_FIRST) && r_wdSh[N-1];
  assign bus.m_burst_en = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_serial_master_port.sv
// ============================================================================
// Module   : tb_serial_master_port
// Purpose  : Directed bench for serial_master_port with a cycle-driven slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_master_port;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
  logic        busy;
`ifdef SERIAL_MASTER_TIMEOUT_EN
  logic        err;
`endif

  serial_master_port_if bus ();

`ifdef SERIAL_MASTER_TIMEOUT_EN
  serial_master_port #(.N(8), .ADN(12), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err), .bus(bus)
  );
`else
  serial_master_port #(.N(8), .ADN(12)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared;
  int nMismatched;
  int doneCount;
  logic burstSeen;

  initial begin
    doneCount = 0;
    burstSeen = 1'b0;
  end

  always @(negedge clk) begin
    if (done) doneCount <= doneCount + 1;
    if (bus.m_burst_en) burstSeen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          startCyc;
  int          doneCyc;
  logic [11:0] addrSeen;
  logic [11:0] dataSeen;
  logic        startOk, validOk, wrenOk, endOk;
  logic [7:0]  rdAtDone;
  logic        busReqAtDone, wrenAtDone, busyAtDone, errAtDone;
  logic        abortOr, idleBusy;

  // One transfer, observed at negedges; n counts cycles after req capture.
  task automatic runXfer(input logic iWr, input logic [11:0] iAddr, input logic [7:0] iWd,
                         input int gDly, input int rDly, input logic gap,
                         input logic [7:0] rByte, input int abortAt);
    logic bv [0:15];
    logic bd [0:15];
    int   addrEnd;
    int   j;
    for (int k = 0; k < 16; k++) begin
      bv[k] = 1'b0;
      bd[k] = 1'b1;
    end
    bv[0] = 1'b1;
    if (!gap) begin
      for (int k = 1; k <= 8; k++) begin
        bv[k] = 1'b1;
        bd[k] = rByte[8-k];
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        bv[k] = 1'b1;
        bd[k] = rByte[8-k];
      end
      for (int k = 7; k <= 10; k++) begin
        bv[k] = 1'b1;
        bd[k] = rByte[10-k];
      end
    end

    startCyc = -1; doneCyc = -1; addrSeen = '0; dataSeen = '0;
    startOk = 1'b0; validOk = 1'b1; wrenOk = 1'b1; endOk = 1'b0;
    rdAtDone = '0; busReqAtDone = 1'b1; wrenAtDone = 1'b1; busyAtDone = 1'b0;
    errAtDone = 1'b0; abortOr = 1'b1; addrEnd = -1;

    @(negedge clk);
    req = 1'b1; wr = iWr; addr = iAddr; wdata = iWd;
    bus.bus_grant = (gDly == 0); bus.s_valid = 1'b0; bus.s_data = 1'b0;

    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      req = (n == 3);
      if (n == 3) begin
        wr = ~iWr; addr = ~iAddr; wdata = ~iWd;
      end
      bus.bus_grant = (n >= gDly + 1);

      if (abortAt > 0 && n == abortAt + 1) begin
        abortOr = |{done, busy, rdata, bus.bus_req, bus.m_valid, bus.m_wren,
                    bus.m_addr, bus.m_data, bus.m_burst_en};
        reset = 1'b0;
        break;
      end
      if (done) begin
        doneCyc = n; rdAtDone = rdata; busReqAtDone = bus.bus_req;
        wrenAtDone = bus.m_wren; busyAtDone = busy;
`ifdef SERIAL_MASTER_TIMEOUT_EN
        errAtDone = err;
`endif
        bus.s_valid = 1'b0;
        break;
      end

      if (bus.m_valid && startCyc < 0) begin
        startCyc = n;
        startOk  = !bus.m_addr && !bus.m_data && (bus.m_wren == iWr);
      end else if (startCyc >= 0 && n <= startCyc + 12) begin
        addrSeen = {addrSeen[10:0], bus.m_addr};
        dataSeen = {dataSeen[10:0], bus.m_data};
        validOk  = validOk & bus.m_valid;
        wrenOk   = wrenOk & (bus.m_wren == iWr);
      end else if (startCyc >= 0 && n == startCyc + 13) begin
        endOk   = !bus.m_valid && !bus.m_data;
        addrEnd = n;
      end

      if (!iWr && addrEnd > 0) begin
        j = n - addrEnd - rDly;
        if (j >= 0 && j < 16) begin
          bus.s_valid = bv[j];
          bus.s_data  = bd[j];
        end else begin
          bus.s_valid = 1'b0;
          bus.s_data  = 1'b0;
        end
      end

      if (abortAt > 0 && n == abortAt) reset = 1'b1;
    end
    req = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    idleBusy = busy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dc0;

  initial begin
    nCompared = 0; nMismatched = 0;
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    bus.bus_grant = 1'b0; bus.s_ready = 1'b1; bus.s_valid = 1'b0; bus.s_data = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {done, busy, rdata, bus.bus_req, bus.m_valid, bus.m_wren,
                         bus.m_addr, bus.m_data, bus.m_burst_en}, 32'h0);
    reset = 1'b0;

    // Write A5C / 3C, grant immediate
    runXfer(1'b1, 12'hA5C, 8'h3C, 0, 0, 1'b0, 8'h00, 0);
    check("wr_start_cyc", startCyc, 2);
    check("wr_start_bits", startOk, 1);
    check("wr_addr_ser", addrSeen, 12'hA5C);
    check("wr_data_ser", dataSeen, 12'h03C);
    check("wr_valid_wren", {validOk, wrenOk}, 2'b11);
    check("wr_valid_drop", endOk, 1);
    check("wr_done_cyc", doneCyc, 17);
    check("wr_done_outs", {busyAtDone, busReqAtDone, wrenAtDone}, 3'b100);
    check("wr_rdata_keep", rdAtDone, 8'h00);
    check("wr_busy_fall", idleBusy, 0);
`ifdef SERIAL_MASTER_TIMEOUT_EN
    check("wr_err", errAtDone, 0);
`endif

    // Read 012, slave returns C9 after 20 cycles
    runXfer(1'b0, 12'h012, 8'h00, 0, 20, 1'b0, 8'hC9, 0);
    check("rd_addr_ser", addrSeen, 12'h012);
    check("rd_data_line", dataSeen, 12'h000);
    check("rd_wren_low", {startOk, wrenOk}, 2'b11);
    check("rd_done_cyc", doneCyc, 44);
    check("rd_rdata", rdAtDone, 8'hC9);
    check("rd_done_outs", {busyAtDone, busReqAtDone, wrenAtDone}, 3'b100);

    // Grant withheld for 7 cycles
    runXfer(1'b1, 12'h3F0, 8'hA6, 7, 0, 1'b0, 8'h00, 0);
    check("gd_start_cyc", startCyc, 9);
    check("gd_addr_ser", addrSeen, 12'h3F0);
    check("gd_data_ser", dataSeen, 12'h0A6);
    check("gd_done_cyc", doneCyc, 24);
    check("gd_rdata_keep", rdAtDone, 8'hC9);

    // Read with a 2-cycle s_valid gap mid-byte
    runXfer(1'b0, 12'h7E1, 8'h00, 0, 3, 1'b1, 8'h81, 0);
    check("gap_done_cyc", doneCyc, 29);
    check("gap_rdata", rdAtDone, 8'h81);

    // Reset on ADDR cycle 5
    dc0 = doneCount;
    runXfer(1'b1, 12'h0F0, 8'hFF, 0, 0, 1'b0, 8'h00, 8);
    check("abort_outs", abortOr, 0);
    check("abort_idle", idleBusy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", doneCount - dc0, 0);

    // Normal write after abort
    runXfer(1'b1, 12'h2AA, 8'h55, 0, 0, 1'b0, 8'h00, 0);
    check("post_addr_ser", addrSeen, 12'h2AA);
    check("post_data_ser", dataSeen, 12'h055);
    check("post_done_cyc", doneCyc, 17);
    check("post_rdata", rdAtDone, 8'h00);

`ifdef SERIAL_MASTER_TIMEOUT_EN
    // Read whose slave never answers: timeout after 10 RD_WAIT cycles
    runXfer(1'b0, 12'h123, 8'h00, 0, 1000, 1'b0, 8'h00, 0);
    check("to_done_cyc", doneCyc, 25);
    check("to_err", errAtDone, 1);
    check("to_bus_req", busReqAtDone, 0);
    check("to_rdata_keep", rdAtDone, 8'h00);
`endif

    check("burst_low", burstSeen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire
